data_mem: RTL and testbench

Single-port data memory that acts as the responder to the MEM stage's load/store requests. It accepts one request at a time over a valid/ready handshake and performs byte, halfword or word accesses. Read data is sign- or zero-extended to 32 bits. Every request, read or write, is answered after a programmable latency through a valid/ready response channel. It sits between the MEM stage and the MEM/WB pipeline register, and lets the pipeline stall on memory latency.

---
 rtl/data_mem_pkg.sv | 71 +++++++
 rtl/data_mem_array.sv | 28 ++
 rtl/data_mem.sv | 122 ++++++++++++
 tb/tb_data_mem.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the data memory responder: size codes,
// FSM states, lane steering for stores and extension for loads.
package data_mem_pkg;

    localparam int REG_BUS = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic result;
        case (size)
            SIZE_BYTE: result = 1'b0;
            SIZE_HALF: result = offset[0];
            SIZE_WORD: result = (offset != 2'b00);
            default:   result = 1'b1;
        endcase
        return result;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] result;
        case (size)
            SIZE_BYTE: result = 4'b0001 << offset;
            SIZE_HALF: result = offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: result = 4'b1111;
            default:   result = 4'b0000;
        endcase
        return result;
    endfunction

    // Replicating the right-aligned data lets the strobe alone pick the lane.
    function automatic logic [REG_BUS-1:0] store_align(input logic [1:0] size,
                                                       input logic [REG_BUS-1:0] wdata);
        logic [REG_BUS-1:0] result;
        case (size)
            SIZE_BYTE: result = {4{wdata[7:0]}};
            SIZE_HALF: result = {2{wdata[15:0]}};
            default:   result = wdata;
        endcase
        return result;
    endfunction

    function automatic logic [REG_BUS-1:0] load_extend(input logic [REG_BUS-1:0] word,
                                                       input logic [1:0] size,
                                                       input logic is_unsigned,
                                                       input logic [1:0] offset);
        logic [7:0]         b;
        logic [15:0]        h;
        logic [REG_BUS-1:0] result;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: result = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_HALF: result = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default:   result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised storage with per-byte write enables; the read side is
// combinational so the parent decides when to capture it.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic [3:0]         be,
    input  logic [AW-1:0]      addr,
    input  logic [REG_BUS-1:0] wdata,
    output logic [REG_BUS-1:0] rdata
);

    logic [REG_BUS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem.sv
// Load/store responder for the MEM stage: one outstanding request, fixed
// latency, registered response held until the consumer takes it.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [1:0]         req_size_i,
    input  logic               req_unsigned_i,
    input  logic [REG_BUS-1:0] req_addr_i,
    input  logic [REG_BUS-1:0] req_wdata_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [REG_BUS-1:0] rsp_rdata_o,
    output logic               rsp_err_o
);

    localparam int AW = $clog2(DEPTH);

    state_e             state, next_state;
    logic [3:0]         cnt;
    logic [REG_BUS-1:0] addr_q;
    logic [1:0]         size_q;
    logic               unsigned_q, write_q;

    logic               accept;
    logic [REG_BUS-1:0] cur_addr;
    logic [1:0]         cur_size;
    logic               cur_unsigned, cur_write, cur_err;
    logic [3:0]         be;
    logic [REG_BUS-1:0] array_rdata;

    logic               ready_d, valid_d, load_resp;
    logic [REG_BUS-1:0] rdata_d;

    assign accept = (state == ST_IDLE) && req_ready_o && req_valid_i;

    // With LATENCY=1 the response is loaded on the accept edge itself, so the
    // live request fields must be used instead of the not-yet-latched copies.
    assign cur_addr     = accept ? req_addr_i     : addr_q;
    assign cur_size     = accept ? req_size_i     : size_q;
    assign cur_unsigned = accept ? req_unsigned_i : unsigned_q;
    assign cur_write    = accept ? req_write_i    : write_q;

    assign cur_err = misaligned(cur_size, cur_addr[1:0])
                   || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH));

    assign be = (accept && req_write_i && !cur_err) ? store_strobe(req_size_i, req_addr_i[1:0])
                                                    : 4'b0000;

    data_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .be    (be),
        .addr  (cur_addr[AW+1:2]),
        .wdata (store_align(req_size_i, req_wdata_i)),
        .rdata (array_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt        <= 4'(LATENCY - 1);
                addr_q     <= req_addr_i;
                size_q     <= req_size_i;
                unsigned_q <= req_unsigned_i;
                write_q    <= req_write_i;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt <= 4'd1) next_state = ST_RESP;
            ST_RESP: if (rsp_ready_i) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_d   = (next_state == ST_IDLE);
        valid_d   = (next_state == ST_RESP);
        load_resp = valid_d && (state != ST_RESP);
        rdata_d   = (cur_err || cur_write) ? '0
                  : load_extend(array_rdata, cur_size, cur_unsigned, cur_addr[1:0]);
    end

    // Response data is captured only on entry to RESP so a stall holds it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            req_ready_o <= ready_d;
            rsp_valid_o <= valid_d;
            if (load_resp) begin
                rsp_rdata_o <= rdata_d;
                rsp_err_o   <= cur_err;
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: a vector table of complete transactions plus
// hand-written stall and mid-request reset sequences.
module tb_data_mem;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    data_mem #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_write_i    (req_write),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err)
    );

    typedef struct {
        string       name;
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   total_checks  = 0;
    int   passed_checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        total_checks++;
        if (actual === required) passed_checks++;
        else $display("[TB] FAIL %s: actual=%08h required=%08h", name, actual, required);
    endtask

    function automatic vec_t mk_vec(input string name, input logic wr, input logic [1:0] size,
                                    input logic uns, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                    input logic exp_err);
        vec_t v;
        v.name = name; v.write = wr; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    function automatic void add_vec(input string name, input logic wr, input logic [1:0] size,
                                    input logic uns, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                    input logic exp_err);
        vecs.push_back(mk_vec(name, wr, size, uns, addr, wdata, exp_rdata, exp_err));
    endfunction

    // Holds the request until the accept edge, then drops valid just after it.
    task automatic issueRequest(input vec_t v, output bit ok);
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = v.write; req_size = v.size;
        req_unsigned = v.uns; req_addr = v.addr; req_wdata = v.wdata;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        ok = req_ready;
        if (!ok) begin
            checkOutput({v.name, "_ready_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic waitResponse(output int edges);
        edges = 0;
        @(negedge clk);
        while (!rsp_valid && edges < 50) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bit ok;
        int edges;
        issueRequest(v, ok);
        if (ok) begin
            waitResponse(edges);
            checkOutput({v.name, "_latency"}, 32'(edges), 32'(LATENCY - 1));
            checkOutput({v.name, "_rdata"}, rsp_rdata, v.exp_rdata);
            checkOutput({v.name, "_err"}, 32'(rsp_err), 32'(v.exp_err));
            handshake();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit   ok;
        int   edges;
        vec_t v;

        add_vec("sw_10",     1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0);
        add_vec("lw_10",     0, 2'd2, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0);
        add_vec("sw_20",     1, 2'd2, 0, 32'h20,   32'h8070F0FF, 32'h0,        0);
        add_vec("lb_20",     0, 2'd0, 0, 32'h20,   32'h0,        32'hFFFFFFFF, 0);
        add_vec("lbu_21",    0, 2'd0, 1, 32'h21,   32'h0,        32'h000000F0, 0);
        add_vec("lh_22",     0, 2'd1, 0, 32'h22,   32'h0,        32'hFFFF8070, 0);
        add_vec("lhu_22",    0, 2'd1, 1, 32'h22,   32'h0,        32'h00008070, 0);
        add_vec("lb_23",     0, 2'd0, 0, 32'h23,   32'h0,        32'h00000080 | 32'hFFFFFF00, 0);
        add_vec("sw_30a",    1, 2'd2, 0, 32'h30,   32'h11223344, 32'h0,        0);
        add_vec("sb_31",     1, 2'd0, 0, 32'h31,   32'h123456AA, 32'h0,        0);
        add_vec("lw_30a",    0, 2'd2, 0, 32'h30,   32'h0,        32'h1122AA44, 0);
        add_vec("sw_30b",    1, 2'd2, 0, 32'h30,   32'h11223344, 32'h0,        0);
        add_vec("sh_32",     1, 2'd1, 0, 32'h32,   32'h5555BEEF, 32'h0,        0);
        add_vec("lw_30b",    0, 2'd2, 0, 32'h30,   32'h0,        32'hBEEF3344, 0);
        add_vec("sw_40",     1, 2'd2, 0, 32'h40,   32'hCAFEF00D, 32'h0,        0);
        add_vec("lw_41",     0, 2'd2, 0, 32'h41,   32'h0,        32'h0,        1);
        add_vec("sh_43",     1, 2'd1, 0, 32'h43,   32'h0000FFFF, 32'h0,        1);
        add_vec("lh_41",     0, 2'd1, 0, 32'h41,   32'h0,        32'h0,        1);
        add_vec("lw_40",     0, 2'd2, 0, 32'h40,   32'h0,        32'hCAFEF00D, 0);
        add_vec("lw_1000",   0, 2'd2, 0, 32'h1000, 32'h0,        32'h0,        1);
        add_vec("size3_40",  0, 2'd3, 0, 32'h40,   32'h0,        32'h0,        1);
        add_vec("sw_04",     1, 2'd2, 0, 32'h04,   32'h01020304, 32'h0,        0);
        add_vec("sw_1004",   1, 2'd2, 0, 32'h1004, 32'hBADBAD00, 32'h0,        1);
        add_vec("lw_04",     0, 2'd2, 0, 32'h04,   32'h0,        32'h01020304, 0);
        add_vec("lb_ffc",    0, 2'd0, 1, 32'hFFC,  32'h0,        32'h0,        0);

        // Reset asserted from time zero: everything quiet, ready follows release.
        #3;
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_err",   32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("rel_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 checkOutput("rel_ready_high", 32'(req_ready), 32'd1);

        // Word 0xFFC is otherwise never written; give it a known value first.
        applyStimulus(mk_vec("sw_ffc", 1, 2'd2, 0, 32'hFFC, 32'h0, 32'h0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Response stall: outputs frozen, no new request accepted.
        v = mk_vec("stall_lw", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        issueRequest(v, ok);
        if (ok) begin
            waitResponse(edges);
            for (int i = 0; i < 5; i++) begin
                checkOutput($sformatf("stall%0d_valid", i), 32'(rsp_valid), 32'd1);
                checkOutput($sformatf("stall%0d_rdata", i), rsp_rdata, 32'hDEADBEEF);
                checkOutput($sformatf("stall%0d_err", i),   32'(rsp_err), 32'd0);
                checkOutput($sformatf("stall%0d_ready", i), 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            handshake();
            checkOutput("post_stall_ready", 32'(req_ready), 32'd1);
            checkOutput("post_stall_valid", 32'(rsp_valid), 32'd0);
            req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
            req_unsigned = 1'b0; req_addr = 32'h40;
            @(posedge clk);
            #1 req_valid = 1'b0;
            checkOutput("next_accept_ready", 32'(req_ready), 32'd0);
            waitResponse(edges);
            checkOutput("next_accept_latency", 32'(edges), 32'(LATENCY - 1));
            checkOutput("next_accept_rdata", rsp_rdata, 32'hCAFEF00D);
            handshake();
        end

        // Reset while a load sits in WAIT: outputs clear without a clock edge.
        v = mk_vec("rst_wait_lw", 0, 2'd2, 0, 32'h10, 32'h0, 32'h0, 0);
        issueRequest(v, ok);
        if (ok) begin
            #2 rst = 1'b0;
            #1;
            checkOutput("wait_rst_valid", 32'(rsp_valid), 32'd0);
            checkOutput("wait_rst_ready", 32'(req_ready), 32'd0);
            checkOutput("wait_rst_rdata", rsp_rdata, 32'h0);
            checkOutput("wait_rst_err",   32'(rsp_err), 32'd0);
            repeat (2) @(negedge clk);
            checkOutput("wait_rst_hold_valid", 32'(rsp_valid), 32'd0);
            rst = 1'b1;
            #1 checkOutput("wait_rel_ready_low", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1 checkOutput("wait_rel_ready_high", 32'(req_ready), 32'd1);
            checkOutput("wait_rel_valid", 32'(rsp_valid), 32'd0);
        end
        applyStimulus(mk_vec("lw_10_after_rst", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        applyStimulus(mk_vec("lhu_32_after_rst", 0, 2'd1, 1, 32'h32, 32'h0, 32'h0000BEEF, 0));

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
